// File: rtl/dsp_pkg.sv
// Shared DSP library definitions: output-mode encodings and elaboration-time
// helpers used to size adder trees.
package dsp_pkg;

    typedef enum int {
        OM_FULL = 0,
        OM_WRAP = 1,
        OM_SAT  = 2
    } out_mode_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Number of elements present after lvl halving levels of an n-element tree.
    function automatic int level_count(input int n, input int unsigned lvl);
        int c;
        c = n;
        for (int unsigned i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

endpackage

// File: rtl/pyramid_sum_level.sv
// One registered level of the adder tree: pairs adjacent elements, passes an
// odd trailing element through unchanged, and carries valid/tlast alongside.
module pyramid_sum_level
    import dsp_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int W     = 8,
    localparam int N_OUT = (N_IN + 1) / 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en_i,
    input  logic [N_IN*W-1:0]  data_i,
    input  logic               valid_i,
    input  logic               last_i,
    output logic [N_OUT*W-1:0] data_o,
    output logic               valid_o,
    output logic               last_o
);

    logic [N_OUT*W-1:0] sum_d;
    logic [N_OUT*W-1:0] data_q;
    logic               valid_q;
    logic               last_q;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        if (2 * j + 1 < N_IN) begin : g_add
            assign sum_d[j*W +: W] = data_i[(2*j)*W +: W] + data_i[(2*j+1)*W +: W];
        end else begin : g_pass
            assign sum_d[j*W +: W] = data_i[(2*j)*W +: W];
        end
    end

    // Level register: flush on reset/clear, otherwise advance with the global enable.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (en_i) begin
            data_q  <= sum_d;
            valid_q <= valid_i;
            last_q  <= last_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/pyramid_sum_axis.sv
// Pipelined AXI-stream adder tree: sums SIZE lanes per beat with lossless
// growth, rounded right-shift scaling and full/wrap/saturate output.
module pyramid_sum_axis
    import dsp_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SIZE     = 18,
    parameter int SIGNED   = 1,
    parameter int SHIFT    = 0,
    parameter int OUT_MODE = OM_FULL,
    localparam int GROWTH  = clog2(SIZE),
    localparam int LEVELS  = GROWTH,
    localparam int OUT_W   = (OUT_MODE == OM_FULL) ? WIDTH + GROWTH : WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [SIZE*WIDTH-1:0] i_tdata,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic [OUT_W-1:0]      o_tdata,
    output logic                  o_tlast,
    output logic                  o_sat,
    output logic                  o_tvalid,
    input  logic                  o_tready
);

    // Tree element width: enough headroom that no level can overflow.
    localparam int EW = WIDTH + GROWTH + 1;
    localparam logic signed [EW:0] RND =
        (SHIFT > 0) ? ((EW + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic [SIZE*EW-1:0] lanes_ext;
    logic [EW-1:0]      tree_sum;
    logic               tree_valid;
    logic               tree_last;
    logic               en;

    logic signed [EW:0] rsum;
    logic signed [EW:0] rshift;
    logic               over;
    logic [OUT_W-1:0]   data_d;
    logic               sat_d;
    logic [OUT_W-1:0]   data_q;
    logic               sat_q;
    logic               valid_q;
    logic               last_q;

    // Whole pipeline moves together; it only holds when the output beat is stuck.
    assign en       = o_tready | ~valid_q;
    assign i_tready = en;

    for (genvar k = 0; k < SIZE; k++) begin : g_ext
        if (SIGNED != 0) begin : g_sext
            assign lanes_ext[k*EW +: EW] =
                {{(GROWTH + 1){i_tdata[(k+1)*WIDTH-1]}}, i_tdata[k*WIDTH +: WIDTH]};
        end else begin : g_zext
            assign lanes_ext[k*EW +: EW] = {{(GROWTH + 1){1'b0}}, i_tdata[k*WIDTH +: WIDTH]};
        end
    end

    if (LEVELS == 0) begin : g_bypass
        assign tree_sum   = lanes_ext;
        assign tree_valid = i_tvalid;
        assign tree_last  = i_tlast;
    end else begin : g_tree
        for (genvar n = 0; n < LEVELS; n++) begin : g_lvl
            localparam int NI = level_count(SIZE, n);
            localparam int NO = level_count(SIZE, n + 1);
            logic [NI*EW-1:0] din;
            logic             vin;
            logic             lin;
            logic [NO*EW-1:0] dout;
            logic             vout;
            logic             lout;
            if (n == 0) begin : g_head
                assign din = lanes_ext;
                assign vin = i_tvalid;
                assign lin = i_tlast;
            end else begin : g_link
                assign din = g_lvl[n-1].dout;
                assign vin = g_lvl[n-1].vout;
                assign lin = g_lvl[n-1].lout;
            end
            pyramid_sum_level #(
                .N_IN (NI),
                .W    (EW)
            ) u_level (
                .clk     (clk),
                .reset   (reset),
                .clear   (clear),
                .en_i    (en),
                .data_i  (din),
                .valid_i (vin),
                .last_i  (lin),
                .data_o  (dout),
                .valid_o (vout),
                .last_o  (lout)
            );
        end
        assign tree_sum   = g_lvl[LEVELS-1].dout;
        assign tree_valid = g_lvl[LEVELS-1].vout;
        assign tree_last  = g_lvl[LEVELS-1].lout;
    end

    // Output scaling: round-half-up shift, then full/wrap/saturate selection.
    always_comb begin
        rsum   = '0;
        rshift = '0;
        over   = 1'b0;
        data_d = '0;
        sat_d  = 1'b0;
        if (SIGNED != 0) begin
            rsum   = {tree_sum[EW-1], tree_sum} + RND;
            rshift = rsum >>> SHIFT;
            over   = ~((&rshift[EW:WIDTH-1]) | ~(|rshift[EW:WIDTH-1]));
        end else begin
            rsum   = {1'b0, tree_sum} + RND;
            rshift = rsum >> SHIFT;
            over   = |rshift[EW:WIDTH];
        end
        data_d = rshift[OUT_W-1:0];
        if (OUT_MODE == OM_WRAP) begin
            sat_d = over;
        end else if (OUT_MODE == OM_SAT && over) begin
            sat_d = 1'b1;
            if (SIGNED != 0) begin
                data_d = rshift[EW] ? {1'b1, {(OUT_W - 1){1'b0}}} : {1'b0, {(OUT_W - 1){1'b1}}};
            end else begin
                data_d = '1;
            end
        end
    end

    // Output register: flush on reset/clear, hold while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data_q  <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (en) begin
            data_q  <= data_d;
            sat_q   <= sat_d & tree_valid;
            valid_q <= tree_valid;
            last_q  <= tree_last;
        end
    end

    assign o_tdata  = data_q;
    assign o_sat    = sat_q;
    assign o_tvalid = valid_q;
    assign o_tlast  = last_q;

endmodule

// File: tb/tb_pyramid_sum_axis.sv
// Bench for pyramid_sum_axis: several parameterisations share one stimulus
// stream; a per-instance arithmetic model feeds a scoreboard, and directed
// beats pin latency and literal results.
module tb_pyramid_sum_axis;

    localparam int W  = 16;
    localparam int NI = 8;
    localparam int P_SIZE [NI] = '{18, 18, 18, 18, 18, 1, 3, 18};
    localparam int P_SGN  [NI] = '{1, 1, 1, 1, 1, 1, 1, 0};
    localparam int P_SH   [NI] = '{0, 0, 0, 2, 1, 0, 0, 0};
    localparam int P_MODE [NI] = '{0, 2, 1, 0, 0, 0, 0, 2};
    localparam int P_OW   [NI] = '{21, 16, 16, 21, 21, 16, 18, 16};

    logic clk = 1'b0;
    logic reset, clear, i_tvalid, i_tlast, o_tready;
    logic [18*W-1:0] din;
    logic [NI-1:0] irdy, ov, ol, os;
    logic [20:0] d0, d3, d4;
    logic [15:0] d1, d2, d5, d7;
    logic [17:0] d6;
    logic signed [63:0] od [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pyramid_sum_axis #(.WIDTH(W), .SIZE(18), .SIGNED(1), .SHIFT(0), .OUT_MODE(0)) u0 (
        .clk(clk), .reset(reset), .clear(clear), .i_tdata(din), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(irdy[0]), .o_tdata(d0), .o_tlast(ol[0]),
        .o_sat(os[0]), .o_tvalid(ov[0]), .o_tready(o_tready));
    pyramid_sum_axis #(.WIDTH(W), .SIZE(18), .SIGNED(1), .SHIFT(0), .OUT_MODE(2)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .i_tdata(din), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(irdy[1]), .o_tdata(d1), .o_tlast(ol[1]),
        .o_sat(os[1]), .o_tvalid(ov[1]), .o_tready(o_tready));
    pyramid_sum_axis #(.WIDTH(W), .SIZE(18), .SIGNED(1), .SHIFT(0), .OUT_MODE(1)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .i_tdata(din), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(irdy[2]), .o_tdata(d2), .o_tlast(ol[2]),
        .o_sat(os[2]), .o_tvalid(ov[2]), .o_tready(o_tready));
    pyramid_sum_axis #(.WIDTH(W), .SIZE(18), .SIGNED(1), .SHIFT(2), .OUT_MODE(0)) u3 (
        .clk(clk), .reset(reset), .clear(clear), .i_tdata(din), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(irdy[3]), .o_tdata(d3), .o_tlast(ol[3]),
        .o_sat(os[3]), .o_tvalid(ov[3]), .o_tready(o_tready));
    pyramid_sum_axis #(.WIDTH(W), .SIZE(18), .SIGNED(1), .SHIFT(1), .OUT_MODE(0)) u4 (
        .clk(clk), .reset(reset), .clear(clear), .i_tdata(din), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(irdy[4]), .o_tdata(d4), .o_tlast(ol[4]),
        .o_sat(os[4]), .o_tvalid(ov[4]), .o_tready(o_tready));
    pyramid_sum_axis #(.WIDTH(W), .SIZE(1), .SIGNED(1), .SHIFT(0), .OUT_MODE(0)) u5 (
        .clk(clk), .reset(reset), .clear(clear), .i_tdata(din[15:0]), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(irdy[5]), .o_tdata(d5), .o_tlast(ol[5]),
        .o_sat(os[5]), .o_tvalid(ov[5]), .o_tready(o_tready));
    pyramid_sum_axis #(.WIDTH(W), .SIZE(3), .SIGNED(1), .SHIFT(0), .OUT_MODE(0)) u6 (
        .clk(clk), .reset(reset), .clear(clear), .i_tdata(din[47:0]), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(irdy[6]), .o_tdata(d6), .o_tlast(ol[6]),
        .o_sat(os[6]), .o_tvalid(ov[6]), .o_tready(o_tready));
    pyramid_sum_axis #(.WIDTH(W), .SIZE(18), .SIGNED(0), .SHIFT(0), .OUT_MODE(2)) u7 (
        .clk(clk), .reset(reset), .clear(clear), .i_tdata(din), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(irdy[7]), .o_tdata(d7), .o_tlast(ol[7]),
        .o_sat(os[7]), .o_tvalid(ov[7]), .o_tready(o_tready));

    always_comb begin
        od[0] = $signed(d0);
        od[1] = $signed(d1);
        od[2] = $signed(d2);
        od[3] = $signed(d3);
        od[4] = $signed(d4);
        od[5] = $signed(d5);
        od[6] = $signed(d6);
        od[7] = {48'd0, d7};
    end

    function automatic longint wrapw(input longint v, input int w, input int sg);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (sg != 0 && m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    // Expected output of instance k for one beat, straight from the arithmetic rules.
    function automatic void model(input logic [18*W-1:0] lanes, input int k,
                                  output longint data, output bit sat);
        longint s, r, lo, hi;
        logic [15:0] v;
        s = 0;
        for (int i = 0; i < P_SIZE[k]; i++) begin
            v = lanes[i*W +: W];
            s = s + ((P_SGN[k] != 0) ? longint'($signed(v)) : longint'(v));
        end
        r = s;
        if (P_SH[k] > 0) r = (s + (longint'(1) << (P_SH[k] - 1))) >>> P_SH[k];
        lo = (P_SGN[k] != 0) ? -32768 : 0;
        hi = (P_SGN[k] != 0) ? 32767 : 65535;
        sat = 1'b0;
        data = wrapw(r, P_OW[k], P_SGN[k]);
        if (P_MODE[k] == 1) begin
            sat  = (r < lo) || (r > hi);
            data = wrapw(r, 16, P_SGN[k]);
        end else if (P_MODE[k] == 2) begin
            sat  = (r < lo) || (r > hi);
            data = (r < lo) ? lo : ((r > hi) ? hi : r);
        end
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        longint d;
        bit     s;
        bit     l;
    } exp_t;

    exp_t q [NI][$];
    bit   sb_on = 1'b0;
    bit   bp_on = 1'b0;
    int   nstall = 0;
    int   nout0  = 0;
    logic [NI-1:0] stall_prev = '0;
    logic signed [63:0] prev_d [NI];
    logic [NI-1:0] prev_l, prev_s;

    // Scoreboard: sampled mid-cycle, sees exactly what the next edge will transfer.
    always @(negedge clk) begin
        exp_t e;
        if (sb_on) begin
            if (bp_on && !irdy[0]) nstall++;
            if (bp_on && ov[0] && o_tready) nout0++;
            if (reset || clear) begin
                for (int k = 0; k < NI; k++) q[k].delete();
                stall_prev = '0;
            end else begin
                for (int k = 0; k < NI; k++) begin
                    if (stall_prev[k]) begin
                        total++;
                        if (!ov[k] || od[k] !== prev_d[k] || ol[k] !== prev_l[k] || os[k] !== prev_s[k]) begin
                            bad++;
                            $display("FAIL hold[%0d]: got v=%0b d=%0d l=%0b s=%0b expected v=1 d=%0d l=%0b s=%0b",
                                     k, ov[k], od[k], ol[k], os[k], prev_d[k], prev_l[k], prev_s[k]);
                        end
                    end
                    if (ov[k] && o_tready) begin
                        total++;
                        if (q[k].size() == 0) begin
                            bad++;
                            $display("FAIL ghost[%0d]: got beat d=%0d expected no beat", k, od[k]);
                        end else begin
                            e = q[k].pop_front();
                            if (od[k] !== e.d || os[k] !== e.s || ol[k] !== e.l) begin
                                bad++;
                                $display("FAIL sb[%0d]: got d=%0d sat=%0b last=%0b expected d=%0d sat=%0b last=%0b",
                                         k, od[k], os[k], ol[k], e.d, e.s, e.l);
                            end
                        end
                    end
                    if (i_tvalid && irdy[k]) begin
                        model(din, k, e.d, e.s);
                        e.l = i_tlast;
                        q[k].push_back(e);
                    end
                    stall_prev[k] = ov[k] && !o_tready;
                    prev_d[k] = od[k];
                    prev_l[k] = ol[k];
                    prev_s[k] = os[k];
                end
            end
        end
    end

    int lat_r [NI];
    logic signed [63:0] dat_r [NI];
    logic [NI-1:0] sat_r, lst_r;

    // Single beat into an idle pipeline; records per-instance latency and result.
    task automatic one_beat(input logic [18*W-1:0] v, input logic last);
        din = v;
        i_tlast = last;
        i_tvalid = 1'b1;
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        for (int k = 0; k < NI; k++) lat_r[k] = 0;
        for (int e = 1; e <= 12; e++) begin
            for (int k = 0; k < NI; k++) begin
                if (lat_r[k] == 0 && ov[k]) begin
                    lat_r[k] = e;
                    dat_r[k] = od[k];
                    sat_r[k] = os[k];
                    lst_r[k] = ol[k];
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [18*W-1:0] v;
        logic ok;
        int g, seen;
        reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1; din = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ovalid", ov, 0);
        chk("rst_odata0", od[0], 0);
        chk("rst_odata1", od[1], 0);
        chk("rst_osat", os, 0);
        chk("rst_olast", ol, 0);
        chk("rst_itready", irdy, 8'hFF);
        sb_on = 1'b1;

        // Lanes 1..18
        for (int k = 0; k < 18; k++) v[k*W +: W] = 16'(k + 1);
        one_beat(v, 1'b1);
        chk("v1_sum", dat_r[0], 171);
        chk("v1_last", lst_r[0], 1);
        chk("v1_sat", sat_r[0], 0);
        chk("v1_lat", lat_r[0], 6);
        chk("v1_shift2", dat_r[3], 43);
        chk("s1_lat", lat_r[5], 1);
        chk("s1_sum", dat_r[5], 1);
        chk("s3_lat", lat_r[6], 3);
        chk("s3_sum", dat_r[6], 6);

        // All lanes at the most negative value
        for (int k = 0; k < 18; k++) v[k*W +: W] = 16'h8000;
        one_beat(v, 1'b0);
        chk("v2_full", dat_r[0], -589824);
        chk("v2_full_sat", sat_r[0], 0);
        chk("v2_last", lst_r[0], 0);
        chk("v2_satmode", dat_r[1], -32768);
        chk("v2_satmode_sat", sat_r[1], 1);
        chk("v2_wrap", dat_r[2], 0);
        chk("v2_wrap_sat", sat_r[2], 1);
        chk("v2_uns_clamp", dat_r[7], 65535);
        chk("v2_uns_sat", sat_r[7], 1);

        // All lanes -1
        for (int k = 0; k < 18; k++) v[k*W +: W] = 16'hFFFF;
        one_beat(v, 1'b1);
        chk("v3_shift1", dat_r[4], -9);
        chk("v3_shift2", dat_r[3], -4);
        chk("v3_full", dat_r[0], -18);

        // Back-to-back stream with a 3-cycle downstream stall
        nstall = 0;
        nout0 = 0;
        bp_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    for (int k = 0; k < 18; k++) din[k*W +: W] = 16'(i * 4099 + k * 7919);
                    i_tlast = (i % 3 == 2);
                    i_tvalid = 1'b1;
                    ok = 1'b0;
                    g = 0;
                    while (!ok && g < 40) begin
                        #1;
                        ok = irdy[0];
                        @(posedge clk);
                        #1;
                        g++;
                    end
                    chk("bp_accept", ok, 1);
                end
                i_tvalid = 1'b0;
            end
            begin
                for (int w = 0; w < 40 && !ov[0]; w++) begin
                    @(posedge clk);
                    #1;
                end
                repeat (2) @(posedge clk);
                #1;
                o_tready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                o_tready = 1'b1;
            end
        join
        repeat (15) @(posedge clk);
        #1;
        bp_on = 1'b0;
        chk("bp_stall_cycles", nstall, 3);
        chk("bp_out_count", nout0, 10);

        // Flush with four beats in flight and a fifth offered on the clear edge
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 18; k++) din[k*W +: W] = 16'(1000 * (i + 1) + k);
            i_tvalid = 1'b1;
            if (i == 4) clear = 1'b1;
            @(posedge clk);
            #1;
        end
        clear = 1'b0;
        i_tvalid = 1'b0;
        chk("clr_ovalid", ov, 0);
        chk("clr_odata", od[0], 0);
        chk("clr_osat", os, 0);
        chk("clr_olast", ol, 0);
        chk("clr_itready", irdy, 8'hFF);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (|ov) seen++;
        end
        chk("clr_no_emerge", seen, 0);
        for (int k = 0; k < 18; k++) v[k*W +: W] = 16'(k + 1);
        one_beat(v, 1'b1);
        chk("post_clr_lat", lat_r[0], 6);
        chk("post_clr_sum", dat_r[0], 171);
        chk("post_clr_s3_lat", lat_r[6], 3);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pyramid_sum_axis.md
# pyramid_sum_axis

Pipelined, fully handshaked adder tree that sums SIZE parallel WIDTH-bit lanes into one result per accepted beat. Supports signed/unsigned arithmetic, lossless bit growth, rounded right-shift scaling and selectable wrap/saturate output. Stalls correctly under backpressure and carries tlast alongside the data. Sits in the DSP library between parallel multiplier banks (FIR taps, correlators, beamformers) and downstream AXI-stream consumers.

## Interface
- WIDTH, 16, bits per input lane
- SIZE, 18, number of input lanes (≥1)
- SIGNED, 1, 1 = two's-complement lanes, 0 = unsigned
- SHIFT, 0, right shift applied to the full sum with round-half-up (0..GROWTH+WIDTH-1)
- OUT_MODE, 0, 0 = full width, 1 = wrap to WIDTH, 2 = saturate to WIDTH
- Derived: GROWTH = clog2(SIZE); LEVELS = GROWTH; OUT_W = WIDTH+GROWTH if OUT_MODE=0, else WIDTH; LAT = LEVELS+1
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clear  in  1  synchronous flush, same effect as reset
- i_tdata  in  SIZE*WIDTH  lane k at bits [(k+1)*WIDTH-1 : k*WIDTH]
- i_tlast  in  1  frame marker, delivered with the matching sum
- i_tvalid  in  1  input beat valid
- i_tready  out  1  input accepted when i_tvalid & i_tready
- o_tdata  out  OUT_W  scaled sum
- o_tlast  out  1  delayed i_tlast
- o_sat  out  1  wrap/clamp occurred on this beat (always 0 in OUT_MODE 0)
- o_tvalid  out  1  output beat valid
- o_tready  in  1  downstream ready

## Operation
- Each lane is sign- (SIGNED=1) or zero-extended to WIDTH+GROWTH+1 bits on entry; all tree arithmetic uses this width, so overflow inside the tree cannot occur.
- Level n pairs adjacent elements (2j, 2j+1) and registers each sum. An odd trailing element is registered unchanged into the next level. Element count per level: ceil(prev/2).
- Output stage (registered): r = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, arithmetic shift when SIGNED, logical otherwise.
  - OUT_MODE 0: o_tdata = r[OUT_W-1:0]; o_sat = 0.
  - OUT_MODE 1: o_tdata = r[WIDTH-1:0]; o_sat = 1 if r is outside the WIDTH range.
  - OUT_MODE 2: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1] (signed) or [0, 2^WIDTH-1] (unsigned); o_sat = 1 if clamped.
- Every stage carries a valid bit and tlast. Global advance: en = o_tready | ~o_tvalid. All stages shift only when en=1. Input is captured when i_tvalid & en.
- i_tready = en (combinational from o_tready and o_tvalid).
- A beat with i_tvalid=0 on an advancing cycle inserts a bubble (valid=0). Bubbles are not collapsed.
- SIZE=1: no tree levels; the lane passes through the output stage only.

## Timing
- Latency is exactly LAT cycles from acceptance to o_tvalid, in the absence of stalls. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while o_tready=1.
- While o_tvalid=1 and o_tready=0, o_tdata, o_tlast and o_sat hold stable, and no stage changes.
- reset/clear: on the next edge, all valid bits go to 0 and all data/tlast/sat registers go to 0. Afterwards o_tvalid=0, o_tdata=0, o_tlast=0, o_sat=0, and i_tready=1. In-flight beats are discarded. clear has priority over a simultaneous accept.
- A beat accepted in the same cycle that clear is asserted is dropped.

## Structure
- Shared package/include dsp_pkg holds: clog2 function, OUT_MODE encodings (OM_FULL=0, OM_WRAP=1, OM_SAT=2).
- Sub-module pyramid_sum_level: one registered tree level (parameters N_IN, W). Handles the odd passthrough and the valid/tlast registers. Instantiated LEVELS times via generate.
- Output scaling/saturation stage is implemented inline in the top level.

## Test plan
- Reset: assert reset 2 cycles -> o_tvalid=0, o_tdata=0, o_sat=0, i_tready=1.
- WIDTH=16, SIZE=18, SIGNED=1, OUT_MODE=0: lanes k = k+1 (1..18), tlast=1 -> after 6 cycles o_tdata=171, o_tlast=1, o_sat=0.
- All lanes = -32768 -> OUT_MODE 0: o_tdata=-589824 (21 bits), o_sat=0. OUT_MODE 2: o_tdata=-32768, o_sat=1. OUT_MODE 1: o_tdata=0, o_sat=1.
- SHIFT=2, lanes 1..18 -> o_tdata=43 ((171+2)>>2). Lanes all -1 with SHIFT=1 -> (-18+1)>>>1 = -9.
- Backpressure: 10 back-to-back beats with o_tready low for 3 cycles mid-stream -> 10 correct sums in order, no loss or duplication, i_tready=0 exactly in the stalled cycles, outputs stable while stalled.
- clear asserted while 4 beats are in flight -> o_tvalid=0 next cycle, those beats never emerge. A subsequent beat emerges after 6 cycles. SIZE=1 and SIZE=3 variants give latency 1 and 3 respectively.
